fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register, directly upstream of decode.
- Holds the PC and issues reads to a synchronous instruction memory with a fixed 1-cycle read latency.
- Presents instruction, PC and valid to decode.
- Absorbs decode load-use stalls with a 1-entry skid buffer.
- Applies execute redirects (always-not-taken recovery) and stops fetching on halt.

Parameters:
RESET_ADDR, 32'h0000_0000, first PC fetched after reset
NOP_INST, 32'h0000_0013, addi x0,x0,0; value driven on o_inst when not valid

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset; asynchronous, active-low
i_stall  in  1  decode load-use stall; hold IF/ID
i_flush  in  1  execute redirect (branch taken / jump)
i_redirect_pc  in  32  redirect target, sampled when i_flush=1
i_halt  in  1  decode reports valid halt (ecall/ebreak opcode)
o_imem_addr  out  32  instruction memory read address
o_imem_ren  out  1  instruction memory read enable
i_imem_rdata  in  32  read data, valid the cycle after o_imem_ren
o_inst  out  32  IF/ID instruction, to decode
o_pc  out  32  IF/ID PC
o_pc_plus4  out  32  o_pc + 4
o_valid  out  1  IF/ID valid, to decode prev_valid
o_halted  out  1  fetch permanently stopped

Behaviour:
Reset (i_rst=0, asynchronous):
- pc=RESET_ADDR, req_valid=0, req_pc=RESET_ADDR, skid empty, halted=0.
- o_valid=0, o_inst=NOP_INST, o_pc=RESET_ADDR, o_halted=0.
- o_imem_ren=0 while reset is asserted.
- Reset asserted mid-operation discards all state, including in-flight reads.

Combinational outputs:
- o_imem_ren = i_rst & ~halted & ~i_stall & ~i_flush & ~i_halt.
- o_imem_addr = pc.
- o_pc_plus4 = o_pc + 32'd4, wraps mod 2^32.

States:
- RUN: skid empty.
- HOLD: skid full.
- HALTED: terminal until reset.

Per clock edge, in priority order:
1. i_flush:
   - pc<=i_redirect_pc, req_valid<=0, skid emptied, o_valid<=0, o_inst<=NOP_INST, state RUN.
   - i_halt in the same cycle is ignored, because the halt is on the wrong path.
2. i_halt:
   - halted<=1, o_halted<=1, req_valid<=0, skid emptied, o_valid<=0, state HALTED.
   - No further reads are issued.
3. i_stall:
   - IF/ID registers hold.
   - If req_valid, the arriving {i_imem_rdata, req_pc} is captured into skid; state HOLD; req_valid<=0.
4. Otherwise:
   - If skid full: IF/ID<=skid, o_valid<=1, skid emptied.
   - Else if req_valid: IF/ID<={i_imem_rdata, req_pc}, o_valid<=1.
   - Else: o_valid<=0.
5. If o_imem_ren: req_valid<=1, req_pc<=pc, pc<=pc+4.

Guarantees and timing:
- At most one read is in flight, so a 1-entry skid is sufficient. Because o_imem_ren=0 while stalled, the skid never overflows.
- Latency: the first o_valid=1 occurs at the 2nd rising edge after reset release, with o_pc=RESET_ADDR.
- Redirect penalty: flush at edge k; the target is requested after edge k; o_valid with o_pc=target at edge k+2.
- Stall release: skid drains and a new read issues in the same cycle, so there is no bubble.
- pc wraps mod 2^32; there is no alignment trap here (pc[1:0] is always 0 by construction; redirect targets are trusted).
- o_inst=NOP_INST whenever o_valid=0 after a flush, halt or reset, so decode sees a harmless instruction.

Decomposition:
- Shared package fetch_pkg: RESET_ADDR default, NOP_INST, 2-bit state encoding (RUN, HOLD, HALTED), INST_W=32.
- One sub-module: fetch_skid_buf. It is a 1-entry {inst, pc} buffer with load/drain/clear and full flag, async active-low reset, and the same clock/reset names.

Test Plan:
- Reset release, memory word[i]=32'h0000_0013+(i<<7), no stall → o_valid rises at the 2nd edge; o_pc sequence 0,4,8,C with matching o_inst; one read per cycle.
- Stall for 3 cycles while the read of pc 8 is in flight → IF/ID holds pc 4; skid holds pc 8; o_imem_ren=0 during the stall; after release o_pc is 8 then C, with no bubble and no duplicate.
- i_flush with i_redirect_pc=32'h100 during a stall with skid full → skid cleared; o_valid=0 for 2 cycles; then o_pc=32'h100 with mem[0x100].
- i_halt at pc 32'h10 → o_halted=1 next edge; o_imem_ren stays 0 for 20 cycles; o_valid=0.
- i_halt and i_flush (target 32'h40) in the same cycle → no halt; fetch resumes at 32'h40.
- i_rst asserted asynchronously mid-stall with skid full → all outputs at reset values immediately, with no clock; after release fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_pkg;
  localparam int          INST_W         = 32;
  localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST   = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst, pc} holding buffer that catches a read returning while decode stalls.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [INST_W-1:0] wr_inst,
  input  logic [31:0]       wr_pc,
  output logic [INST_W-1:0] rd_inst,
  output logic [31:0]       rd_pc,
  output logic              full
);
  logic              full_reg;
  logic [INST_W-1:0] inst_reg;
  logic [31:0]       pc_reg;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      full_reg <= 1'b0;
      inst_reg <= '0;
      pc_reg   <= '0;
    end else begin
      if (clear || drain) full_reg <= 1'b0;
      else if (load)      full_reg <= 1'b1;
      if (load) begin
        inst_reg <= wr_inst;
        pc_reg   <= wr_pc;
      end
    end
  end

  assign rd_inst = inst_reg;
  assign rd_pc   = pc_reg;
  assign full    = full_reg;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: PC, 1-cycle imem read, stall skid, redirect and halt.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0]       RESET_ADDR = DEF_RESET_ADDR,
  parameter logic [INST_W-1:0] NOP_INST   = DEF_NOP_INST
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [31:0]       i_redirect_pc,
  input  logic              i_halt,
  output logic [31:0]       o_imem_addr,
  output logic              o_imem_ren,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic [INST_W-1:0] o_inst,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_pc_plus4,
  output logic              o_valid,
  output logic              o_halted
);
  state_t            state_reg, state_next;
  logic [31:0]       pc_reg, req_pc_reg, pc_out_reg;
  logic              req_valid_reg, valid_reg;
  logic [INST_W-1:0] inst_reg;

  logic              halted, ren, skid_load, skid_drain, skid_clear, skid_full;
  logic [INST_W-1:0] skid_inst;
  logic [31:0]       skid_pc;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_reg <= ST_RUN;
    else        state_reg <= state_next;
  end

  // Flush outranks halt: a halt seen alongside a redirect is on the wrong path.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN, ST_HOLD: begin
        if (i_flush)     state_next = ST_RUN;
        else if (i_halt) state_next = ST_HALTED;
        else if (i_stall) begin
          if (req_valid_reg) state_next = ST_HOLD;
        end else         state_next = ST_RUN;
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_comb begin
    halted     = (state_reg == ST_HALTED);
    skid_clear = !halted && (i_flush || i_halt);
    skid_load  = !halted && !i_flush && !i_halt && i_stall && req_valid_reg;
    skid_drain = !halted && !i_flush && !i_halt && !i_stall && skid_full;
    ren        = i_rst && !halted && !i_stall && !i_flush && !i_halt;
  end

  fetch_skid_buf u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .load    (skid_load),
    .drain   (skid_drain),
    .clear   (skid_clear),
    .wr_inst (i_imem_rdata),
    .wr_pc   (req_pc_reg),
    .rd_inst (skid_inst),
    .rd_pc   (skid_pc),
    .full    (skid_full)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc_reg        <= RESET_ADDR;
      req_pc_reg    <= RESET_ADDR;
      req_valid_reg <= 1'b0;
      pc_out_reg    <= RESET_ADDR;
      inst_reg      <= NOP_INST;
      valid_reg     <= 1'b0;
    end else if (!halted) begin
      if (i_flush) begin
        pc_reg        <= i_redirect_pc;
        req_valid_reg <= 1'b0;
        valid_reg     <= 1'b0;
        inst_reg      <= NOP_INST;
      end else if (i_halt) begin
        req_valid_reg <= 1'b0;
        valid_reg     <= 1'b0;
        inst_reg      <= NOP_INST;
      end else if (i_stall) begin
        // The returning word (if any) has gone into the skid; IF/ID holds.
        if (req_valid_reg) req_valid_reg <= 1'b0;
      end else begin
        if (skid_full) begin
          inst_reg   <= skid_inst;
          pc_out_reg <= skid_pc;
          valid_reg  <= 1'b1;
        end else if (req_valid_reg) begin
          inst_reg   <= i_imem_rdata;
          pc_out_reg <= req_pc_reg;
          valid_reg  <= 1'b1;
        end else begin
          valid_reg  <= 1'b0;
          inst_reg   <= NOP_INST;
        end
        req_valid_reg <= ren;
        if (ren) begin
          req_pc_reg <= pc_reg;
          pc_reg     <= pc_reg + 32'd4;
        end
      end
    end
  end

  assign o_imem_addr = pc_reg;
  assign o_imem_ren  = ren;
  assign o_inst      = inst_reg;
  assign o_pc        = pc_out_reg;
  assign o_pc_plus4  = pc_out_reg + 32'd4;
  assign o_valid     = valid_reg;
  assign o_halted    = halted;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle synchronous instruction memory model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, halt = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic        imem_ren;
  logic [31:0] inst, pc, pc_plus4;
  logic        valid, halted;

  int vectors = 0;
  int miscompares = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
    .i_redirect_pc(redirect_pc), .i_halt(halt),
    .o_imem_addr(imem_addr), .o_imem_ren(imem_ren), .i_imem_rdata(imem_rdata),
    .o_inst(inst), .o_pc(pc), .o_pc_plus4(pc_plus4), .o_valid(valid), .o_halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h0000_0013 + ((a >> 2) << 7);
  endfunction

  always @(posedge clk) if (imem_ren) imem_rdata <= word_at(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b0; redirect_pc = 32'h0;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({valid, inst, pc, pc_plus4, halted, imem_ren} !== {1'b0, NOP, 32'h0, 32'h4, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b inst=%h pc=%h pc4=%h halted=%b ren=%b, required 0/%h/0/4/0/0",
               valid, inst, pc, pc_plus4, halted, imem_ren, NOP);
    end
  endtask

  task automatic test_stream();
    do_reset();
    tick();
    vectors++;
    if ({valid, imem_ren, imem_addr} !== {1'b0, 1'b1, 32'h4}) begin
      miscompares++;
      $display("FAIL stream_edge1: valid=%b ren=%b addr=%h, required 0/1/4", valid, imem_ren, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({valid, pc, inst, pc_plus4, imem_ren, imem_addr} !==
          {1'b1, 32'(i*4), word_at(32'(i*4)), 32'(i*4+4), 1'b1, 32'(i*4+8)}) begin
        miscompares++;
        $display("FAIL stream_%0d: valid=%b pc=%h inst=%h pc4=%h ren=%b addr=%h, required 1/%h/%h/%h/1/%h",
                 i, valid, pc, inst, pc_plus4, imem_ren, imem_addr, 32'(i*4), word_at(32'(i*4)),
                 32'(i*4+4), 32'(i*4+8));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) tick();
    stall = 1'b1;
    #1;
    vectors++;
    if (imem_ren !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_ren: ren=%b, required 0", imem_ren);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({valid, pc, inst, imem_ren} !== {1'b1, 32'h4, word_at(32'h4), 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: valid=%b pc=%h inst=%h ren=%b, required 1/4/%h/0",
                 i, valid, pc, inst, imem_ren, word_at(32'h4));
      end
    end
    stall = 1'b0;
    #1;
    vectors++;
    if ({imem_ren, imem_addr} !== {1'b1, 32'hC}) begin
      miscompares++;
      $display("FAIL stall_release_ren: ren=%b addr=%h, required 1/c", imem_ren, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({valid, pc, inst} !== {1'b1, 32'(8 + i*4), word_at(32'(8 + i*4))}) begin
        miscompares++;
        $display("FAIL stall_drain_%0d: valid=%b pc=%h inst=%h, required 1/%h/%h",
                 i, valid, pc, inst, 32'(8 + i*4), word_at(32'(8 + i*4)));
      end
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    repeat (3) tick();
    stall = 1'b1;
    tick();
    flush = 1'b1; redirect_pc = 32'h100;
    #1;
    vectors++;
    if (imem_ren !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ren: ren=%b, required 0", imem_ren);
    end
    tick();
    vectors++;
    if ({valid, inst, imem_addr} !== {1'b0, NOP, 32'h100}) begin
      miscompares++;
      $display("FAIL flush_k: valid=%b inst=%h addr=%h, required 0/%h/100", valid, inst, imem_addr, NOP);
    end
    flush = 1'b0; stall = 1'b0;
    tick();
    vectors++;
    if ({valid, inst} !== {1'b0, NOP}) begin
      miscompares++;
      $display("FAIL flush_k1: valid=%b inst=%h, required 0/%h", valid, inst, NOP);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({valid, pc, inst} !== {1'b1, 32'(32'h100 + i*4), word_at(32'(32'h100 + i*4))}) begin
        miscompares++;
        $display("FAIL flush_target_%0d: valid=%b pc=%h inst=%h, required 1/%h/%h",
                 i, valid, pc, inst, 32'(32'h100 + i*4), word_at(32'(32'h100 + i*4)));
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (6) tick();
    vectors++;
    if ({valid, pc} !== {1'b1, 32'h10}) begin
      miscompares++;
      $display("FAIL halt_pre: valid=%b pc=%h, required 1/10", valid, pc);
    end
    halt = 1'b1;
    #1;
    vectors++;
    if (imem_ren !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_ren: ren=%b, required 0", imem_ren);
    end
    tick();
    halt = 1'b0;
    #1;
    vectors++;
    if ({halted, valid, inst} !== {1'b1, 1'b0, NOP}) begin
      miscompares++;
      $display("FAIL halt_edge: halted=%b valid=%b inst=%h, required 1/0/%h", halted, valid, inst, NOP);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if ({imem_ren, valid, halted} !== {1'b0, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL halt_hold_%0d: ren=%b valid=%b halted=%b, required 0/0/1", i, imem_ren, valid, halted);
      end
    end
  endtask

  task automatic test_halt_flush();
    do_reset();
    repeat (2) tick();
    halt = 1'b1; flush = 1'b1; redirect_pc = 32'h40;
    tick();
    halt = 1'b0; flush = 1'b0;
    #1;
    vectors++;
    if ({halted, valid, imem_ren, imem_addr} !== {1'b0, 1'b0, 1'b1, 32'h40}) begin
      miscompares++;
      $display("FAIL halt_flush_k: halted=%b valid=%b ren=%b addr=%h, required 0/0/1/40",
               halted, valid, imem_ren, imem_addr);
    end
    repeat (2) tick();
    vectors++;
    if ({valid, pc, inst} !== {1'b1, 32'h40, word_at(32'h40)}) begin
      miscompares++;
      $display("FAIL halt_flush_target: valid=%b pc=%h inst=%h, required 1/40/%h", valid, pc, inst, word_at(32'h40));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (2) tick();
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({valid, pc, pc_plus4, inst} !== {1'b1, 32'hFFFF_FFFC, 32'h0, word_at(32'hFFFF_FFFC)}) begin
      miscompares++;
      $display("FAIL wrap_top: valid=%b pc=%h pc4=%h inst=%h, required 1/fffffffc/0/%h",
               valid, pc, pc_plus4, inst, word_at(32'hFFFF_FFFC));
    end
    tick();
    vectors++;
    if ({valid, pc, inst} !== {1'b1, 32'h0, word_at(32'h0)}) begin
      miscompares++;
      $display("FAIL wrap_zero: valid=%b pc=%h inst=%h, required 1/0/%h", valid, pc, inst, word_at(32'h0));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) tick();
    stall = 1'b1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({valid, inst, pc, pc_plus4, halted, imem_ren, imem_addr} !==
        {1'b0, NOP, 32'h0, 32'h4, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b inst=%h pc=%h pc4=%h halted=%b ren=%b addr=%h, required 0/%h/0/4/0/0/0",
               valid, inst, pc, pc_plus4, halted, imem_ren, imem_addr, NOP);
    end
    stall = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    vectors++;
    if ({valid, imem_addr} !== {1'b0, 32'h4}) begin
      miscompares++;
      $display("FAIL async_restart_e1: valid=%b addr=%h, required 0/4", valid, imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({valid, pc, inst} !== {1'b1, 32'(i*4), word_at(32'(i*4))}) begin
        miscompares++;
        $display("FAIL async_restart_%0d: valid=%b pc=%h inst=%h, required 1/%h/%h",
                 i, valid, pc, inst, 32'(i*4), word_at(32'(i*4)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_stall();
    test_halt();
    test_halt_flush();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
